// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage definitions: default widths, NOP encoding and the
// stage occupancy state encoding.
package pipe_stage_reg_pkg;

  localparam int unsigned NBITS_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

endpackage : pipe_stage_reg_pkg

// File: rtl/pipe_skid_entry.sv
// One {pc, instruction} payload register with load enable and synchronous
// active-low reset; used for both the main and the skid entry.
module pipe_skid_entry #(
  parameter int unsigned NBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [NBITS-1:0] pc,
  input  logic [NBITS-1:0] instr,
  output logic [NBITS-1:0] pc_q,
  output logic [NBITS-1:0] instr_q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else if (load) begin
      pc_q    <= pc;
      instr_q <= instr;
    end
  end

endmodule : pipe_skid_entry

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register for {pc, instruction} with optional
// skid entry (fully registered o_ready) and flush-to-bubble.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned      NBITS     = NBITS_DEFAULT,
  parameter bit               SKID_EN   = 1'b1,
  parameter logic [NBITS-1:0] NOP_INSTR = NBITS'(NOP_INSTR_DEFAULT)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [NBITS-1:0] i_pc,
  input  logic [NBITS-1:0] i_instruction,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [NBITS-1:0] o_pc,
  output logic [NBITS-1:0] o_instruction,
  output logic             o_skid_full
);

  state_e           state;
  logic             accept;
  logic             issue;
  logic             main_load;
  logic [NBITS-1:0] main_d_pc;
  logic [NBITS-1:0] main_d_instr;
  logic [NBITS-1:0] main_pc;
  logic [NBITS-1:0] main_instr;
  logic [NBITS-1:0] skid_pc;
  logic [NBITS-1:0] skid_instr;

  assign o_valid = (state != ST_EMPTY);
  assign issue   = o_valid & i_ready;
  assign accept  = i_valid & o_ready;

  // Occupancy FSM; flush empties the stage, reset outranks everything.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_EMPTY;
    end else if (i_flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state <= ST_FULL;
        ST_FULL: begin
          if (accept && !issue) begin
            if (SKID_EN) state <= ST_SKID;
          end else if (!accept && issue) begin
            state <= ST_EMPTY;
          end
        end
        ST_SKID:  if (issue) state <= ST_FULL;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // Main entry refills from the input, or from the skid entry when draining it.
  always_comb begin
    main_load    = 1'b0;
    main_d_pc    = i_pc;
    main_d_instr = i_instruction;
    if (!i_flush) begin
      case (state)
        ST_EMPTY: main_load = accept;
        ST_FULL:  main_load = accept & issue;
        ST_SKID: begin
          main_load    = issue;
          main_d_pc    = skid_pc;
          main_d_instr = skid_instr;
        end
        default:  main_load = 1'b0;
      endcase
    end
  end

  pipe_skid_entry #(
    .NBITS (NBITS)
  ) u_main (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load    (main_load),
    .pc      (main_d_pc),
    .instr   (main_d_instr),
    .pc_q    (main_pc),
    .instr_q (main_instr)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic skid_load;

      // Capture the incoming beat only when the main entry is stalled.
      assign skid_load   = ~i_flush & (state == ST_FULL) & accept & ~issue;
      assign o_ready     = (state != ST_SKID);
      assign o_skid_full = (state == ST_SKID);

      pipe_skid_entry #(
        .NBITS (NBITS)
      ) u_skid (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .load    (skid_load),
        .pc      (i_pc),
        .instr   (i_instruction),
        .pc_q    (skid_pc),
        .instr_q (skid_instr)
      );
    end else begin : g_no_skid
      assign skid_pc     = '0;
      assign skid_instr  = '0;
      assign o_ready     = i_ready | ~o_valid;
      assign o_skid_full = 1'b0;
    end
  endgenerate

  assign o_pc          = main_pc;
  assign o_instruction = o_valid ? main_instr : NOP_INSTR;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: scoreboard of accepted beats checked by
// an independent monitor, plus direct checks of the control outputs.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst_n;

  // Skid-enabled DUT
  logic        valid, ready, flush;
  logic [31:0] pc, instr;
  logic        o_ready, o_valid, skid_full;
  logic [31:0] o_pc, o_instr;

  // Skid-disabled DUT
  logic        valid_n, ready_n, flush_n;
  logic [31:0] pc_n, instr_n;
  logic        o_ready_n, o_valid_n, skid_full_n;
  logic [31:0] o_pc_n, o_instr_n;

  int    tests;
  int    fails;
  beat_t sb[$];
  beat_t mon_e;

  pipe_stage_reg #(
    .NBITS     (32),
    .SKID_EN   (1'b1),
    .NOP_INSTR (NOP)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid),
    .o_ready       (o_ready),
    .i_pc          (pc),
    .i_instruction (instr),
    .i_flush       (flush),
    .o_valid       (o_valid),
    .i_ready       (ready),
    .o_pc          (o_pc),
    .o_instruction (o_instr),
    .o_skid_full   (skid_full)
  );

  pipe_stage_reg #(
    .NBITS     (32),
    .SKID_EN   (1'b0),
    .NOP_INSTR (NOP)
  ) dut_ns (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid_n),
    .o_ready       (o_ready_n),
    .i_pc          (pc_n),
    .i_instruction (instr_n),
    .i_flush       (flush_n),
    .o_valid       (o_valid_n),
    .i_ready       (ready_n),
    .o_pc          (o_pc_n),
    .o_instruction (o_instr_n),
    .o_skid_full   (skid_full_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] ins);
    valid = v;
    pc    = p;
    instr = ins;
  endtask

  task automatic expect_beat(input logic [31:0] p, input logic [31:0] ins);
    beat_t b;
    b.pc    = p;
    b.instr = ins;
    sb.push_back(b);
  endtask

  // Monitor: every issued beat must be the oldest outstanding accepted beat.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_valid === 1'b1 && ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got pc %h instr %h, expected no beat", o_pc, o_instr);
      end else begin
        mon_e = sb.pop_front();
        chk("beat_pc", o_pc, mon_e.pc);
        chk("beat_instr", o_instr, mon_e.instr);
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    valid = 1'b0; ready = 1'b0; flush = 1'b0; pc = '0; instr = '0;
    valid_n = 1'b0; ready_n = 1'b0; flush_n = 1'b0; pc_n = '0; instr_n = '0;

    // Reset state
    step();
    step();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_instr", o_instr, NOP);
    chk("rst_skid", 32'(skid_full), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_ns_ready", 32'(o_ready_n), 32'd1);
    chk("rst_ns_instr", o_instr_n, NOP);
    rst_n = 1'b1;

    // First beat, one-cycle latency
    ready = 1'b1;
    drive(1'b1, 32'h4, 32'h00A0_0093);
    expect_beat(32'h4, 32'h00A0_0093);
    step();
    chk("first_valid", 32'(o_valid), 32'd1);
    chk("first_pc", o_pc, 32'h4);
    chk("first_instr", o_instr, 32'h00A0_0093);
    chk("first_ready", 32'(o_ready), 32'd1);
    drive(1'b0, '0, '0);
    step();
    chk("first_drain", 32'(o_valid), 32'd0);

    // Back-to-back stream at full rate
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4), 32'h1000_0013 + 32'(i));
      expect_beat(32'(i * 4), 32'h1000_0013 + 32'(i));
      step();
      chk("stream_valid", 32'(o_valid), 32'd1);
      chk("stream_pc", o_pc, 32'(i * 4));
      chk("stream_skid", 32'(skid_full), 32'd0);
    end
    drive(1'b0, '0, '0);
    step();
    chk("stream_drain", 32'(o_valid), 32'd0);

    // Stall fills the skid entry, then drains in order
    ready = 1'b0;
    drive(1'b1, 32'h10, 32'h0000_1010);
    expect_beat(32'h10, 32'h0000_1010);
    step();
    chk("stall_pc", o_pc, 32'h10);
    chk("stall_ready_full", 32'(o_ready), 32'd1);
    drive(1'b1, 32'h14, 32'h0000_1414);
    expect_beat(32'h14, 32'h0000_1414);
    step();
    chk("skid_full", 32'(skid_full), 32'd1);
    chk("skid_ready", 32'(o_ready), 32'd0);
    chk("skid_pc", o_pc, 32'h10);
    chk("skid_instr", o_instr, 32'h0000_1010);
    drive(1'b0, '0, '0);
    step();
    chk("skid_hold_pc", o_pc, 32'h10);
    chk("skid_hold_valid", 32'(o_valid), 32'd1);
    ready = 1'b1;
    step();
    chk("skid_drain_pc", o_pc, 32'h14);
    chk("skid_drain_full", 32'(skid_full), 32'd0);
    chk("skid_drain_ready", 32'(o_ready), 32'd1);
    step();
    chk("skid_empty_valid", 32'(o_valid), 32'd0);
    chk("skid_empty_instr", o_instr, NOP);
    chk("skid_empty_pc_hold", o_pc, 32'h14);

    // Flush from SKID with a beat on the input
    ready = 1'b0;
    drive(1'b1, 32'h20, 32'h0000_2020);
    expect_beat(32'h20, 32'h0000_2020);
    step();
    drive(1'b1, 32'h24, 32'h0000_2424);
    expect_beat(32'h24, 32'h0000_2424);
    step();
    chk("flush_pre_skid", 32'(skid_full), 32'd1);
    drive(1'b1, 32'h28, 32'h0000_2828);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    sb.delete();
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_instr", o_instr, NOP);
    chk("flush_ready", 32'(o_ready), 32'd1);
    chk("flush_skid", 32'(skid_full), 32'd0);
    ready = 1'b1;
    step();
    step();
    chk("flush_quiet", 32'(o_valid), 32'd0);

    // Flush coinciding with an issue still delivers the held beat
    drive(1'b1, 32'h30, 32'h0000_3030);
    expect_beat(32'h30, 32'h0000_3030);
    step();
    drive(1'b1, 32'h34, 32'h0000_3434);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_issue_sb", 32'(sb.size()), 32'd0);
    chk("flush_issue_valid", 32'(o_valid), 32'd0);
    step();

    // Reset while in SKID discards both entries
    ready = 1'b0;
    drive(1'b1, 32'h40, 32'h0000_4040);
    expect_beat(32'h40, 32'h0000_4040);
    step();
    drive(1'b1, 32'h44, 32'h0000_4444);
    expect_beat(32'h44, 32'h0000_4444);
    step();
    chk("rst2_pre_skid", 32'(skid_full), 32'd1);
    drive(1'b0, '0, '0);
    rst_n = 1'b0;
    step();
    chk("rst2_valid", 32'(o_valid), 32'd0);
    chk("rst2_pc", o_pc, 32'h0);
    chk("rst2_instr", o_instr, NOP);
    chk("rst2_skid", 32'(skid_full), 32'd0);
    chk("rst2_ready", 32'(o_ready), 32'd1);
    rst_n = 1'b1;
    sb.delete();
    ready = 1'b1;
    step();
    chk("rst2_quiet", 32'(o_valid), 32'd0);

    // No-skid build: combinational ready, in-place replacement
    ready_n = 1'b0;
    valid_n = 1'b1; pc_n = 32'h50; instr_n = 32'h0000_5050;
    step();
    chk("ns_valid", 32'(o_valid_n), 32'd1);
    chk("ns_pc", o_pc_n, 32'h50);
    chk("ns_ready_stall", 32'(o_ready_n), 32'd0);
    chk("ns_skid", 32'(skid_full_n), 32'd0);
    pc_n = 32'h54; instr_n = 32'h0000_5454;
    step();
    chk("ns_stall_pc", o_pc_n, 32'h50);
    chk("ns_stall_instr", o_instr_n, 32'h0000_5050);
    ready_n = 1'b1;
    #1;
    chk("ns_ready_comb", 32'(o_ready_n), 32'd1);
    step();
    chk("ns_replace_pc", o_pc_n, 32'h54);
    chk("ns_replace_instr", o_instr_n, 32'h0000_5454);
    chk("ns_replace_valid", 32'(o_valid_n), 32'd1);
    valid_n = 1'b0;
    step();
    chk("ns_drain", 32'(o_valid_n), 32'd0);
    chk("ns_drain_instr", o_instr_n, NOP);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register carrying {pc, instruction} between fetch and decode, and reusable for later stages. Adds to the basic IF/ID latch:
- valid/ready handshake;
- optional 2-entry skid buffer so upstream ready is fully registered;
- flush with bubble insertion, driving a NOP instruction whenever the output is invalid.

Sits between the fetch unit (upstream) and the decode/hazard logic (downstream).

Parameters:
NBITS, 32, width of pc and instruction fields
SKID_EN, 1, 1 = two-entry skid buffer with registered o_ready; 0 = single entry, o_ready = i_ready | ~o_valid
NOP_INSTR, 32'h0000_0000, instruction value driven when o_valid = 0; width NBITS

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst_n  in  1  synchronous active-low reset
i_valid  in  1  upstream beat valid
o_ready  out  1  stage can accept a beat this cycle
i_pc  in  NBITS  upstream pc
i_instruction  in  NBITS  upstream instruction
i_flush  in  1  discard all held and incoming beats (branch/jump taken)
o_valid  out  1  output beat valid
i_ready  in  1  downstream accepts; deasserted by the hazard unit to stall
o_pc  out  NBITS  held pc
o_instruction  out  NBITS  held instruction, or NOP_INSTR when o_valid = 0
o_skid_full  out  1  skid entry occupied; debug/perf; always 0 when SKID_EN = 0

Behaviour:
- Reset is sampled only on the rising edge of i_clk, with i_rst_n = 0.
- Reset values:
  - state EMPTY, o_valid = 0, o_pc = 0, o_instruction = NOP_INSTR, o_skid_full = 0;
  - o_ready = 1 from the first cycle after reset.
- Reset has priority over all other inputs, and a mid-transfer reset discards both entries.
- Handshake definitions:
  - accept = i_valid & o_ready;
  - issue = o_valid & i_ready.
- Beats are never duplicated, dropped (except by flush) or reordered.
- Latency is 1 cycle from accept to o_valid when the stage is empty.
- i_pc and i_instruction are sampled only on accept and may change freely otherwise.
- State machine (SKID_EN = 1), states EMPTY / FULL / SKID; o_valid = (state != EMPTY); o_ready = (state != SKID):
  - EMPTY: accept -> FULL, main <= in.
  - FULL:
    - accept & issue -> FULL, main <= in;
    - accept & ~issue -> SKID, skid <= in;
    - ~accept & issue -> EMPTY;
    - otherwise hold.
  - SKID: o_ready = 0, so no accept. issue -> FULL, main <= skid; otherwise hold.
  - o_ready depends only on state and is never combinational from i_ready.
- SKID_EN = 0: states EMPTY/FULL only.
  - o_ready = i_ready | ~o_valid, combinational;
  - the skid register is not instantiated.
- Outputs o_pc and o_instruction are always the main entry.
  - o_instruction is forced to NOP_INSTR when o_valid = 0.
  - o_pc holds its last value when invalid; it is 0 only after reset.
- Flush (i_flush = 1 at the edge):
  - next state EMPTY, o_skid_full = 0;
  - any beat accepted in the same cycle is discarded;
  - an issue in the same cycle still counts as delivered downstream;
  - flush has priority over accept/issue but not over reset.
- Stall: i_ready held low keeps the output stable for any duration.
  - o_valid, o_pc and o_instruction must not change while o_valid & ~i_ready.
- Only the pc and instruction payload is carried; no arithmetic.

Decomposition:
- Shared pipeline package: NBITS default, NOP_INSTR constant, and the 2-bit state encoding (EMPTY = 0, FULL = 1, SKID = 2).
- Sub-module: pipe_skid_entry, a single NBITS×2 payload register with load enable and synchronous active-low reset.
  - Instantiate it once for the main entry.
  - Instantiate it a second time for the skid entry under generate when SKID_EN = 1.

Test Plan:
- Reset, then i_valid = 1, pc = 0x4, instr = 0x00A00093, i_ready = 1 -> next cycle o_valid = 1, o_pc = 0x4, o_instruction = 0x00A00093, o_ready = 1.
- Stream pc 0x0, 0x4, 0x8, … every cycle with i_ready = 1 -> one beat out per cycle, in order, 1-cycle latency, o_skid_full never 1.
- Hold FULL with pc 0x10, drop i_ready, send pc 0x14 -> o_skid_full = 1, o_ready = 0, output stays 0x10. Raise i_ready -> 0x10 issued, then 0x14, then EMPTY.
- In the SKID state with pc 0x20 (main) and 0x24 (skid), assert i_flush while i_valid = 1 with pc 0x28 -> next cycle o_valid = 0, o_instruction = NOP_INSTR, o_ready = 1; 0x24 and 0x28 never appear.
- i_rst_n = 0 for one edge while in SKID -> o_valid = 0, o_pc = 0, o_instruction = NOP_INSTR, o_skid_full = 0, o_ready = 1.
- SKID_EN = 0 build, FULL with i_ready = 0 -> o_ready = 0 in the same cycle. i_ready = 1 with i_valid = 1 -> o_ready = 1 combinationally and the new beat replaces the old one on the edge.
